// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
package alu_pkg;

  localparam int          OWNER_W = 1;
  localparam logic [4:0]  OP_HALT = 5'b00000;

  typedef logic [OWNER_W-1:0] owner_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, ALU issue and response signals of the shared-ALU arbiter.
interface alu_share_arb_if #(parameter int DW = 16);

    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [4:0]    req0_aluop, req1_aluop;
    logic [1:0]    req0_func,  req1_func;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;

    logic          alu_go;
    logic [4:0]    alu_aluop;
    logic [1:0]    alu_func;
    logic [DW-1:0] alu_a, alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_err;

    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp0_data,  rsp1_data;
    logic          rsp0_err,   rsp1_err;

    // The arbiter's view.
    modport slave (
        input  req0_valid, req1_valid, req0_aluop, req1_aluop, req0_func, req1_func,
               req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_go, alu_aluop, alu_func, alu_a, alu_b,
        input  alu_result, alu_err,
        output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_err, rsp1_err,
        input  rsp0_ready, rsp1_ready
    );

    // The requesters' and ALU's view.
    modport master (
        output req0_valid, req1_valid, req0_aluop, req1_aluop, req0_func, req1_func,
               req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_go, alu_aluop, alu_func, alu_a, alu_b,
        output alu_result, alu_err,
        input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_err, rsp1_err,
        output rsp0_ready, rsp1_ready
    );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins; on contention the requester
// that did not win last time wins.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] valid_i,
    input  owner_t     last_grant_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = valid_i[0] & (~valid_i[1] | (last_grant_i == owner_t'(1)));
    assign gnt_o[1] = valid_i[1] & (~valid_i[0] | (last_grant_i == owner_t'(0)));

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one combinational ALU, one operation in
// flight, and returns each result to its owner over valid/ready.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_share_arb_if.slave  bus
);

    state_t        state_q;
    owner_t        owner_q, last_grant_q;
    logic          alu_go_q;
    logic [4:0]    aluop_q;
    logic [1:0]    func_q;
    logic [DW-1:0] a_q, b_q;
    logic [1:0]    rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;

    logic [1:0]    req_valid, gnt, accept, rsp_ready;
    owner_t        acc_owner;
    logic [4:0]    in_aluop;
    logic [1:0]    in_func;
    logic [DW-1:0] in_a, in_b;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    rr_arb2 u_arb (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    // A grant already implies valid, so ready doubles as the accept strobe.
    assign accept    = (state_q == IDLE) ? gnt : 2'b00;
    assign acc_owner = owner_t'(gnt[1]);
    assign in_aluop  = gnt[1] ? bus.req1_aluop : bus.req0_aluop;
    assign in_func   = gnt[1] ? bus.req1_func  : bus.req0_func;
    assign in_a      = gnt[1] ? bus.req1_a     : bus.req0_a;
    assign in_b      = gnt[1] ? bus.req1_b     : bus.req0_b;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= owner_t'(0);
            last_grant_q <= owner_t'(1);
            alu_go_q     <= 1'b0;
            aluop_q      <= '0;
            func_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|accept) begin
                        aluop_q      <= in_aluop;
                        func_q       <= in_func;
                        a_q          <= in_a;
                        b_q          <= in_b;
                        owner_q      <= acc_owner;
                        last_grant_q <= acc_owner;
                        if (in_aluop == OP_HALT) begin
                            // Halt never reaches the ALU; answer with an error.
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= accept;
                            state_q     <= RESP;
                        end else begin
                            alu_go_q <= 1'b1;
                            state_q  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    alu_go_q    <= 1'b0;
                    rsp_data_q  <= bus.alu_result;
                    rsp_err_q   <= bus.alu_err;
                    rsp_valid_q <= (owner_q == owner_t'(1)) ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = accept[0];
    assign bus.req1_ready = accept[1];
    assign bus.alu_go     = alu_go_q;
    assign bus.alu_aluop  = aluop_q;
    assign bus.alu_func   = func_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_data  = rsp_data_q;
    assign bus.rsp1_data  = rsp_data_q;
    assign bus.rsp0_err   = rsp_err_q;
    assign bus.rsp1_err   = rsp_err_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 16-bit execute ALU. It accepts ALU operations from two independent requesters, grants the ALU round-robin, and drives the registered operation code, function bits and operands to the ALU control/datapath. It captures the ALU result and returns it to the owning requester over a valid/ready response channel. It sits between the execute-stage issue logic and the single combinational ALU, with exactly one operation in flight.

## Interface
- `DW`, 16 — operand/result width.
- `clk`  in  1  — system clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `reqN_valid`  in  1  — requester N (N=0,1) has an operation.
- `reqN_ready`  out  1  — arbiter accepts from requester N this cycle.
- `reqN_aluop`  in  5  — 5-bit ALU opcode class.
- `reqN_func`  in  2  — low 2 function bits (R-format select).
- `reqN_a`, `reqN_b`  in  DW  — operands.
- `alu_go`  out  1  — one-cycle strobe: issue registers hold a valid operation.
- `alu_aluop`  out  5  — registered opcode to ALU control.
- `alu_func`  out  2  — registered function bits.
- `alu_a`, `alu_b`  out  DW  — registered operands.
- `alu_result`  in  DW  — combinational ALU result, valid while `alu_go`=1.
- `alu_err`  in  1  — ALU control decode error, valid while `alu_go`=1.
- `rspN_valid`  out  1  — response for requester N is held.
- `rspN_ready`  in  1  — requester N takes the response.
- `rspN_data`  out  DW  — result.
- `rspN_err`  out  1  — operation failed (illegal opcode or decode error).

## Operation
- The FSM has three states: IDLE, EXEC and RESP. All state is cleared on reset.
- **IDLE**
  - `reqN_ready` = 1 only for the granted requester, and only when that requester's valid is high; the other ready is 0.
  - Grant rule: if exactly one valid is high, grant it. If both are high, grant the requester not in `last_grant`.
  - On accept (valid & ready), latch aluop/func/a/b into the issue registers and the owner id into `owner`; set `last_grant` = owner; go to EXEC.
  - If the accepted aluop is 5'b00000 (halt, not an ALU op), skip EXEC: go to RESP with data=0 and err=1.
- **EXEC** (exactly one cycle)
  - `alu_go`=1.
  - At the clock edge, capture `alu_result` into the response data and `alu_err` into the response err; go to RESP.
- **RESP**
  - `rspN_valid`=1 for N = owner only.
  - Data and err stay stable until `rspN_ready`=1; then go to IDLE.
  - Both `reqN_ready` = 0 throughout RESP.
- The issue registers hold their values outside EXEC. `alu_go` qualifies them.
- No data transformation: operands pass to the ALU unchanged, and the result is stored at full DW width.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1 (so requester 0 wins the first contention), `owner`=0.
  - `alu_go`=0, `alu_aluop`=0, `alu_func`=0, `alu_a`=0, `alu_b`=0.
  - `reqN_ready`=0 while no valid is high.
  - `rspN_valid`=0, `rspN_data`=0, `rspN_err`=0.
- Latency for an accept at edge N: `alu_go` is high in cycle N+1, and `rspN_valid` is high from cycle N+2. For a halt accepted at edge N, `rspN_valid` is high from cycle N+1.
- Throughput: at most one operation per 3 cycles. There is no bypass from RESP to IDLE; a new accept occurs no earlier than the cycle after the response handshake.
- If a requester drops valid before acceptance, nothing is recorded. The grant is re-evaluated every IDLE cycle.
- If `rspN_ready` is held high before valid rises, the response completes in its first valid cycle.
- `rspN_ready` of the non-owner is ignored.
- Reset asserted mid-EXEC or mid-RESP drops the in-flight operation: no response is produced and `alu_go` falls asynchronously.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.

## Structure
- Shared package `alu_pkg`:
  - state enum {IDLE, EXEC, RESP};
  - `OP_HALT` = 5'b00000;
  - owner id width (1).
- Sub-module `rr_arb2`: combinational two-way round-robin grant. Inputs: two valids and `last_grant`. Outputs: a one-hot grant.
- Everything else (FSM, issue registers, response registers) lives in `alu_share_arb`.

## Test plan
- Requester 0 sends aluop 5'b01000 (addi), a=0x0005, b=0x0003, with the ALU model returning 0x0008: `alu_go` is seen in cycle N+1, and `rsp0_valid` goes high with data 0x0008, err=0 in cycle N+2.
- Both requesters valid continuously from reset with four ops each: grant order is 0,1,0,1,0,1,0,1; each response reaches only its owner, and `rsp1_valid` is never high for an op owned by 0.
- `rsp1_ready` held low for 5 cycles after `rsp1_valid`: data and err stay stable, both `reqN_ready` stay 0, and the next accept happens one cycle after the handshake.
- Requester 1 sends aluop 5'b00000: `alu_go` is never asserted, and `rsp1_valid` rises in cycle N+1 with data=0x0000, err=1.
- The ALU model asserts `alu_err`=1 for aluop 5'b00110 from requester 0: the response has err=1 and data equal to the captured `alu_result`.
- `rst_n` pulsed low during EXEC: `alu_go` drops immediately, no response is seen, and after release requester 0 wins the first contention.
